// File: rtl/alt_l_cal_ctrl.sv
// Final-key-length job sequencer: launches the s1/e1 estimators, validates e1,
// drives the l-calculation datapath and returns a clamped result with status.
module alt_l_cal_ctrl #(
    parameter int unsigned E1_AMP      = 24,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned TO_W        = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_nleak,
    output logic        o_busy,
    output logic        o_s1_start,
    output logic        o_e1_start,
    input  logic [31:0] i_s1,
    input  logic        i_s1_vld,
    input  logic [31:0] i_e1,
    input  logic        i_e1_vld,
    output logic        o_l_start,
    output logic [31:0] o_e1,
    output logic        o_e1_vld,
    output logic [31:0] o_s1,
    output logic        o_s1_vld,
    output logic [31:0] o_nleak,
    input  logic [31:0] i_l,
    input  logic        i_l_vld,
    input  logic        i_l_error,
    output logic [31:0] o_res,
    output logic [2:0]  o_status,
    output logic        o_res_vld,
    input  logic        i_res_rdy
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 3;

    localparam logic [SW-1:0] ST_OK     = SW'(0);
    localparam logic [SW-1:0] ST_SE_TO  = SW'(1);
    localparam logic [SW-1:0] ST_L_TO   = SW'(2);
    localparam logic [SW-1:0] ST_L_ERR  = SW'(3);
    localparam logic [SW-1:0] ST_E1_RNG = SW'(4);
    localparam logic [SW-1:0] ST_L_NEG  = SW'(5);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_SE, CHECK, FEED, WAIT_L, OUT
    } state_t;

    state_t        state, state_d;
    logic [TO_W-1:0] cnt, cnt_d;
    logic          got_s1, got_s1_d, got_e1, got_e1_d;
    logic [DW-1:0] s1_d, e1_d, nleak_d, res_d;
    logic [SW-1:0] status_d;
    logic          to_hit, e1_bad;

    // Timeout fires on the cycle whose increment would bring the counter to TIMEOUT_CYC
    assign to_hit = (cnt == TO_W'(TIMEOUT_CYC - 1));
    // e1 must lie in 1 .. 2^E1_AMP-1
    assign e1_bad = (o_e1 == '0) || o_e1[DW-1] || (64'(o_e1) >= (64'd1 << E1_AMP));

    // Next-state and next-register-value logic
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        got_s1_d = got_s1;
        got_e1_d = got_e1;
        s1_d     = o_s1;
        e1_d     = o_e1;
        nleak_d  = o_nleak;
        res_d    = o_res;
        status_d = o_status;
        case (state)
            IDLE: begin
                if (i_req) begin
                    nleak_d = i_nleak;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                got_s1_d = 1'b0;
                got_e1_d = 1'b0;
                state_d  = WAIT_SE;
            end
            WAIT_SE: begin
                if (i_s1_vld) begin
                    s1_d     = i_s1;
                    got_s1_d = 1'b1;
                end
                if (i_e1_vld) begin
                    e1_d     = i_e1;
                    got_e1_d = 1'b1;
                end
                if (got_s1_d && got_e1_d) begin
                    state_d = CHECK;
                end else if (to_hit) begin
                    status_d = ST_SE_TO;
                    res_d    = '0;
                    state_d  = OUT;
                end
            end
            CHECK: begin
                if (e1_bad) begin
                    status_d = ST_E1_RNG;
                    res_d    = '0;
                    state_d  = OUT;
                end else begin
                    state_d = FEED;
                end
            end
            FEED: state_d = WAIT_L;
            WAIT_L: begin
                if (i_l_vld) begin
                    if (i_l_error) begin
                        status_d = ST_L_ERR;
                        res_d    = '0;
                    end else if (i_l[DW-1]) begin
                        status_d = ST_L_NEG;
                        res_d    = '0;
                    end else begin
                        status_d = ST_OK;
                        res_d    = i_l;
                    end
                    state_d = OUT;
                end else if (to_hit) begin
                    status_d = ST_L_TO;
                    res_d    = '0;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (o_res_vld && i_res_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_d != state) && ((state_d == WAIT_SE) || (state_d == WAIT_L))) begin
            cnt_d = '0;
        end else if ((state == WAIT_SE) || (state == WAIT_L)) begin
            cnt_d = cnt + TO_W'(1);
        end
    end

    // State, capture and registered-output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            got_s1     <= 1'b0;
            got_e1     <= 1'b0;
            o_s1       <= '0;
            o_e1       <= '0;
            o_nleak    <= '0;
            o_res      <= '0;
            o_status   <= '0;
            o_busy     <= 1'b0;
            o_s1_start <= 1'b0;
            o_e1_start <= 1'b0;
            o_l_start  <= 1'b0;
            o_e1_vld   <= 1'b0;
            o_s1_vld   <= 1'b0;
            o_res_vld  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            got_s1     <= got_s1_d;
            got_e1     <= got_e1_d;
            o_s1       <= s1_d;
            o_e1       <= e1_d;
            o_nleak    <= nleak_d;
            o_res      <= res_d;
            o_status   <= status_d;
            o_busy     <= (state_d != IDLE);
            o_s1_start <= (state_d == LAUNCH);
            o_e1_start <= (state_d == LAUNCH);
            o_l_start  <= (state_d == LAUNCH);
            o_e1_vld   <= (state_d == FEED);
            o_s1_vld   <= (state_d == FEED);
            o_res_vld  <= (state_d == OUT);
        end
    end

endmodule
